clock_div_prog: RTL and testbench
=================================

CLOCK_DIV_PROG -- requirements
Module: clock_div_prog

Interface
REQ-001 SHALL have parameter par_channels, default 2, number of independent divided-clock channels (1..8).
REQ-002 SHALL have parameter par_cnt_width, default 16, divisor and counter width in bits (4..32).
REQ-003 SHALL have parameter par_div_default, default 1000, divisor loaded into every channel at reset (2..2^par_cnt_width-1).
REQ-004 SHALL have port i_clk_mhz  in  1  sole source clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_mhz  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_div_valid  in  1  divisor-load request.
REQ-007 SHALL have port i_div_sel  in  clog2(par_channels) (min 1)  target channel of the load.
REQ-008 SHALL have port i_div_value  in  par_cnt_width  new divisor D.
REQ-009 SHALL have port o_div_ready  out  1  load accepted when high with i_div_valid.
REQ-010 SHALL have port o_clk_div  out  par_channels  divided clocks, registered.
REQ-011 SHALL have port o_rst_div  out  par_channels  per-channel divided-domain resets, registered, active-high.
REQ-012 SHALL have port o_ce_rise  out  par_channels  one-cycle pulse in the source cycle preceding each o_clk_div rising edge.
REQ-013 SHALL have port o_ce_fall  out  par_channels  one-cycle pulse in the source cycle preceding each o_clk_div falling edge.

Function
REQ-014 Each channel SHALL count 0..D-1 and wrap; o_clk_div high for count 0..ceil(D/2)-1, low otherwise (odd D: high one cycle longer than low).
REQ-015 D=0 SHALL stop the channel: counter held at 0, o_clk_div low, o_ce_* low, o_rst_div high.
REQ-016 D=1 SHALL be clamped to D=2.
REQ-017 A load SHALL occur when i_div_valid and o_div_ready are high on the same edge; o_div_ready SHALL be low while the selected channel holds an unapplied pending divisor.
REQ-018 A pending divisor SHALL take effect only at the wrap of the running period (count D-1 -> 0), never mid-period; no o_clk_div pulse shorter than min(old,new) high/low phase.
REQ-019 A load to a stopped channel SHALL take effect on the next edge; first rising edge of o_clk_div one edge after that.
REQ-020 A load to a channel whose pending slot is full SHALL not be accepted (o_div_ready low); i_div_sel out of range SHALL be accepted and discarded.
REQ-021 o_rst_div SHALL stay high through the first divided-clock rising edge after reset release or restart and SHALL fall coincident with the following o_clk_div falling edge.
REQ-022 Channels SHALL be independent; simultaneous wrap on several channels SHALL not interact.

Reset
REQ-023 On i_rst_mhz high, asynchronously: counters 0, active divisor par_div_default, pending empty, o_clk_div 0, o_rst_div all 1, o_ce_* 0, o_div_ready 0.
REQ-024 o_div_ready SHALL go high on the first edge after i_rst_mhz falls; o_clk_div SHALL rise on that same edge (count 0 phase).
REQ-025 Reset asserted mid-period or with a pending load SHALL discard all state and pending divisors.

Configuration
REQ-026 Macro CLOCK_DIV_PROG_RST_OUT_EN defined: o_rst_div generated per REQ-021; undefined: o_rst_div SHALL equal a registered copy of i_rst_mhz (async set, cleared first edge after release) on every channel, independent of D.

Structure
REQ-027 Package clock_div_prog_pkg SHALL hold the divisor/counter typedef (par_cnt_width-based), clamp constant 2, and channel-state enum {STOPPED, RUN_HIGH, RUN_LOW}.
REQ-028 Per-channel logic SHALL be sub-module clock_div_prog_chan, instantiated par_channels times by generate; top holds load decode and ready mux.

Verification
REQ-029 Reset release, defaults (1000) -> o_clk_div period 1000 cycles, 500 high/500 low; o_rst_div falls at first falling edge (cycle 500).
REQ-030 Load D=7 on ch0 mid-period -> current 1000 period completes, then 4 high/3 low; o_ce_rise/o_ce_fall one cycle before each edge.
REQ-031 Load D=0 then D=4 on ch1 -> ch1 low and o_rst_div high while stopped; restart gives 2/2 and o_rst_div falls at first falling edge.
REQ-032 Two back-to-back loads to ch0 within one period -> second stalls with o_div_ready low until wrap, then accepted.
REQ-033 Load D=1 -> behaves as D=2 (1 high/1 low); ch1 unaffected throughout.
REQ-034 Assert i_rst_mhz asynchronously mid-high phase with pending load -> outputs reset immediately without waiting for an edge; pending discarded, default divisor resumes.

Source files
------------

// File: rtl/clock_div_prog_pkg.sv
// Shared types and constants for the programmable clock divider.
package clock_div_prog_pkg;

    localparam int unsigned CNT_WIDTH_MAX = 32;
    localparam int unsigned DIV_CLAMP     = 2;

    // Widest divisor/counter word; a channel keeps the low par_cnt_width bits.
    typedef logic [CNT_WIDTH_MAX-1:0] div_word_t;

    typedef enum logic [1:0] {
        STOPPED,
        RUN_HIGH,
        RUN_LOW
    } chan_state_e;

    function automatic div_word_t clamp_div(input div_word_t d);
        return (d == div_word_t'(1)) ? div_word_t'(DIV_CLAMP) : d;
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_div_prog_chan.sv
// One divided-clock channel: period counter, pending divisor slot, clock/reset/strobe outputs.
// CLOCK_DIV_PROG_RST_OUT_EN selects the per-channel divided-domain reset sequencing.
//
// state    | meaning
// STOPPED  | divisor is 0, clock parked low, reset held
// RUN_HIGH | o_clk_div high phase (count 0 .. ceil(D/2)-1)
// RUN_LOW  | o_clk_div low phase, also the state right after reset
module clock_div_prog_chan
    import clock_div_prog_pkg::*;
#(
    parameter int par_cnt_width   = 16,
    parameter int par_div_default = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [par_cnt_width-1:0] load_value,
    output logic                     pend_full,
    output logic                     clk_div,
    output logic                     rst_div,
    output logic                     ce_rise,
    output logic                     ce_fall
);

    typedef logic [par_cnt_width-1:0] cnt_t;

    chan_state_e state, state_next;
    cnt_t        cnt, cnt_next;
    cnt_t        div_act, div_next;
    cnt_t        pend_val, pend_val_next;
    logic        pend_full_next;
    cnt_t        load_d;
    cnt_t        half;
    logic        stopped;
    logic        term;

    assign load_d  = cnt_t'(clamp_div(div_word_t'(load_value)));
    assign stopped = (div_act == '0);
    assign half    = (div_act >> 1) + cnt_t'(div_act[0]);
    assign term    = (cnt == div_act - cnt_t'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN_LOW;
            clk_div <= 1'b0;
        end else begin
            state   <= state_next;
            clk_div <= (state_next == RUN_HIGH);
        end
    end

    always_comb begin
        state_next = state;
        if (stopped) begin
            state_next = (load && load_d != '0) ? RUN_LOW : STOPPED;
        end else begin
            state_next = (cnt < half) ? RUN_HIGH : RUN_LOW;
        end
    end

    always_comb begin
        ce_rise = !rst && (state_next == RUN_HIGH) && (state != RUN_HIGH);
        ce_fall = !rst && (state == RUN_HIGH) && (state_next != RUN_HIGH);
    end

    // New divisors only land on the period wrap so no phase is ever cut short.
    always_comb begin
        cnt_next       = cnt;
        div_next       = div_act;
        pend_full_next = pend_full;
        pend_val_next  = pend_val;
        if (stopped) begin
            cnt_next = '0;
            if (load) begin
                div_next = load_d;
            end
        end else if (term) begin
            cnt_next = '0;
            if (pend_full) begin
                div_next       = pend_val;
                pend_full_next = 1'b0;
            end
        end else begin
            cnt_next = cnt + cnt_t'(1);
        end
        if (!stopped && load) begin
            pend_val_next  = load_d;
            pend_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            div_act   <= cnt_t'(par_div_default);
            pend_val  <= '0;
            pend_full <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            div_act   <= div_next;
            pend_val  <= pend_val_next;
            pend_full <= pend_full_next;
        end
    end

`ifdef CLOCK_DIV_PROG_RST_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_div <= 1'b1;
        end else if (state_next == STOPPED) begin
            rst_div <= 1'b1;
        end else if (ce_fall) begin
            rst_div <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_div <= 1'b1;
        end else begin
            rst_div <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/clock_div_prog.sv
// Programmable multi-channel clock divider: divisor load decode, ready mux and channel array.
// CLOCK_DIV_PROG_RST_OUT_EN enables sequenced per-channel divided-domain resets.
module clock_div_prog
    import clock_div_prog_pkg::*;
#(
    parameter int par_channels    = 2,
    parameter int par_cnt_width   = 16,
    parameter int par_div_default = 1000
) (
    input  logic                                  i_clk_mhz,
    input  logic                                  i_rst_mhz,
    input  logic                                  i_div_valid,
    input  logic [sel_width(par_channels)-1:0]    i_div_sel,
    input  logic [par_cnt_width-1:0]              i_div_value,
    output logic                                  o_div_ready,
    output logic [par_channels-1:0]               o_clk_div,
    output logic [par_channels-1:0]               o_rst_div,
    output logic [par_channels-1:0]               o_ce_rise,
    output logic [par_channels-1:0]               o_ce_fall
);

    logic                    started;
    logic                    sel_ok;
    logic                    sel_busy;
    logic                    accept;
    logic [par_channels-1:0] pend_full;
    logic [par_channels-1:0] load;

    always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
        if (i_rst_mhz) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // Out-of-range selects are never busy, so they are accepted and dropped.
    assign sel_ok = (32'(i_div_sel) < 32'(par_channels));

    always_comb begin
        sel_busy = 1'b0;
        for (int i = 0; i < par_channels; i++) begin
            if (sel_ok && (32'(i_div_sel) == 32'(i))) begin
                sel_busy = pend_full[i];
            end
        end
    end

    assign o_div_ready = started && !sel_busy;
    assign accept      = i_div_valid && o_div_ready;

    for (genvar g = 0; g < par_channels; g++) begin : g_chan
        assign load[g] = accept && (32'(i_div_sel) == 32'(g));

        clock_div_prog_chan #(
            .par_cnt_width   (par_cnt_width),
            .par_div_default (par_div_default)
        ) u_chan (
            .clk        (i_clk_mhz),
            .rst        (i_rst_mhz),
            .load       (load[g]),
            .load_value (i_div_value),
            .pend_full  (pend_full[g]),
            .clk_div    (o_clk_div[g]),
            .rst_div    (o_rst_div[g]),
            .ce_rise    (o_ce_rise[g]),
            .ce_fall    (o_ce_fall[g])
        );
    end

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed, table-driven bench for clock_div_prog (three channels, default divisor 1000).
module tb_clock_div_prog;

    localparam int NCH = 3;
    localparam int W   = 16;
`ifdef CLOCK_DIV_PROG_RST_OUT_EN
    localparam int RST_HI = 1;
`else
    localparam int RST_HI = 0;
`endif

    typedef struct {
        int ch;
        int d;
        int hi;
        int lo;
    } vec_t;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           valid = 1'b0;
    logic [1:0]     sel   = '0;
    logic [W-1:0]   value = '0;
    logic           ready;
    logic [NCH-1:0] clk_div, rst_div, ce_rise, ce_fall;

    int checks   = 0;
    int failures = 0;
    int ce_err   = 0;

    always #5 clk = ~clk;

    clock_div_prog #(
        .par_channels    (NCH),
        .par_cnt_width   (W),
        .par_div_default (1000)
    ) dut (
        .i_clk_mhz   (clk),
        .i_rst_mhz   (rst),
        .i_div_valid (valid),
        .i_div_sel   (sel),
        .i_div_value (value),
        .o_div_ready (ready),
        .o_clk_div   (clk_div),
        .o_rst_div   (rst_div),
        .o_ce_rise   (ce_rise),
        .o_ce_fall   (ce_fall)
    );

    // Strobes must announce exactly the clock edges seen one cycle later.
    logic [NCH-1:0] p_clk  = '0;
    logic [NCH-1:0] p_rise = '0;
    logic [NCH-1:0] p_fall = '0;
    logic           p_rst  = 1'b1;
    always @(negedge clk) begin
        if (!rst && !p_rst) begin
            if ((clk_div & ~p_clk) != p_rise) ce_err++;
            if ((~clk_div & p_clk) != p_fall) ce_err++;
        end
        p_clk  = clk_div;
        p_rise = ce_rise;
        p_fall = ce_fall;
        p_rst  = rst;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_rise(input int ch);
        logic prev;
        bit   seen;
        int   n;
        prev = clk_div[ch];
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 3000) begin
            step();
            n++;
            if (clk_div[ch] && !prev) seen = 1'b1;
            prev = clk_div[ch];
        end
        check($sformatf("rise_seen_ch%0d", ch), int'(seen), 1);
    endtask

    task automatic measure(input int ch, output int hi, output int lo,
                           output int rh, output int rl);
        hi = 0;
        lo = 0;
        rh = int'(rst_div[ch]);
        while (clk_div[ch] && hi < 3000) begin
            hi++;
            rh = int'(rst_div[ch]);
            step();
        end
        rl = int'(rst_div[ch]);
        while (!clk_div[ch] && lo < 3000) begin
            lo++;
            step();
        end
    endtask

    task automatic load(input int ch, input int d);
        int n;
        n     = 0;
        sel   = 2'(ch);
        value = W'(d);
        #1;
        while (!ready && n < 5000) begin
            step();
            n++;
        end
        check($sformatf("load_ready_ch%0d", ch), int'(ready), 1);
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 5000) begin
            step();
            n++;
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   hi, lo, rh, rl, n, bad;

        vecs[0] = '{0,  1,  1,  1};
        vecs[1] = '{1,  4,  2,  2};
        vecs[2] = '{1,  3,  2,  1};
        vecs[3] = '{0,  2,  1,  1};
        vecs[4] = '{0,  6,  3,  3};
        vecs[5] = '{1,  5,  3,  2};
        vecs[6] = '{0, 20, 10, 10};

        // Reset values and release
        rst = 1'b1;
        repeat (3) step();
        check("rst_clk_div", int'(clk_div), 0);
        check("rst_rst_div", int'(rst_div), 7);
        check("rst_ce", int'(ce_rise | ce_fall), 0);
        check("rst_ready", int'(ready), 0);
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", int'(ready), 0);
        step();
        check("first_edge_clk", int'(clk_div), 7);
        check("first_edge_ready", int'(ready), 1);
        measure(0, hi, lo, rh, rl);
        check("default_hi", hi, 500);
        check("default_lo", lo, 500);
        check("default_rst_through_high", rh, RST_HI);
        check("default_rst_after_fall", rl, 0);

        // Mid-period load: running 1000 period must complete first
        repeat (300) step();
        load(0, 7);
        check("ready_low_pending", int'(ready), 0);
        wait_ready(n);
        check("pending_wait_cycles", n, 698);
        wait_rise(0);
        measure(0, hi, lo, rh, rl);
        check("d7_hi", hi, 4);
        check("d7_lo", lo, 3);
        measure(0, hi, lo, rh, rl);
        check("d7_hi_2", hi, 4);
        check("d7_lo_2", lo, 3);

        // Back-to-back loads: second stalls until the wrap
        sel   = 2'd0;
        value = W'(5);
        #1;
        valid = 1'b1;
        step();
        value = W'(9);
        #1;
        check("ready_stall", int'(ready), 0);
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        check("stall_cycles", n, 5);
        step();
        valid = 1'b0;
        measure(0, hi, lo, rh, rl);
        check("d5_hi", hi, 3);
        check("d5_lo", lo, 2);
        measure(0, hi, lo, rh, rl);
        check("d9_hi", hi, 5);
        check("d9_lo", lo, 4);

        // Out-of-range select is accepted and dropped
        load(0, 9);
        sel = 2'd3;
        #1;
        check("ready_out_of_range", int'(ready), 1);
        value = '0;
        valid = 1'b1;
        step();
        valid = 1'b0;
        sel   = 2'd0;
        #1;
        check("ch0_still_pending", int'(ready), 0);
        wait_rise(2);
        measure(2, hi, lo, rh, rl);
        check("ch2_hi", hi, 500);
        check("ch2_lo", lo, 500);

        // Stop ch1 with D=0, then restart with D=4
        load(1, 0);
        wait_ready(n);
        repeat (3) step();
        bad = 0;
        for (int i = 0; i < 1100; i++) begin
            if (clk_div[1] || int'(rst_div[1]) != RST_HI) bad++;
            step();
        end
        check("ch1_stopped", bad, 0);
        load(1, 4);
        check("ch1_restart_low", int'(clk_div[1]), 0);
        step();
        check("ch1_first_rise", int'(clk_div[1]), 1);
        measure(1, hi, lo, rh, rl);
        check("ch1_restart_hi", hi, 2);
        check("ch1_restart_lo", lo, 2);
        check("ch1_restart_rst_high", rh, RST_HI);
        check("ch1_restart_rst_fall", rl, 0);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            load(vecs[i].ch, vecs[i].d);
            wait_ready(n);
            wait_rise(vecs[i].ch);
            measure(vecs[i].ch, hi, lo, rh, rl);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // Asynchronous reset mid-high phase with a pending load
        load(0, 6);
        check("ready_pending_before_reset", int'(ready), 0);
        n = 0;
        while (!clk_div[0] && n < 100) begin
            step();
            n++;
        end
        step();
        check("ch0_high_before_reset", int'(clk_div[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_clk_div", int'(clk_div), 0);
        check("async_rst_rst_div", int'(rst_div), 7);
        check("async_rst_ce", int'(ce_rise | ce_fall), 0);
        check("async_rst_ready", int'(ready), 0);
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rerelease_clk", int'(clk_div), 7);
        measure(0, hi, lo, rh, rl);
        check("after_rst_hi", hi, 500);
        check("after_rst_lo", lo, 500);

        check("ce_align", ce_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
